// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared definitions for the PC sequencer
package pc_sequencer_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int OFF_W_DEF   = 2;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [5:0] BOOT_ADDR_LO = 6'b000000;
  localparam logic [5:0] BOOT_ADDR_HI = 6'b100000;

  // Encodings are visible on the state port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  // Address the PC loads for a given boot select.
  function automatic logic [5:0] boot_addr(input logic sel);
    return sel ? BOOT_ADDR_HI : BOOT_ADDR_LO;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer control/handshake bundle
interface pc_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int OFF_W  = 2,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              boot_sel;
  logic [ADDR_W-1:0] pc_addr;
  logic              imem_ack;
  logic              instr_branch;
  logic [OFF_W-1:0]  instr_off;
  logic              instr_halt;
  logic              pc_load;
  logic              pc_boot;
  logic              pc_count;
  logic              pc_branch;
  logic [OFF_W-1:0]  pc_add_amt;
  logic              imem_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [2:0]        state;
  logic              halted;
  logic              error;
  logic [CNT_W-1:0]  fetch_count;

  // Sequencer side.
  modport master (
    input  start, boot_sel, pc_addr, imem_ack, instr_branch, instr_off, instr_halt,
    output pc_load, pc_boot, pc_count, pc_branch, pc_add_amt, imem_req,
           fetch_addr, state, halted, error, fetch_count
  );

  // Board / instruction-source side.
  modport slave (
    output start, boot_sel, pc_addr, imem_ack, instr_branch, instr_off, instr_halt,
    input  pc_load, pc_boot, pc_count, pc_branch, pc_add_amt, imem_req,
           fetch_addr, state, halted, error, fetch_count
  );
endinterface

// File: rtl/pc_sequencer_timer.sv
// rtl/pc_sequencer_timer.sv - ack wait timer with clear and expire flag
module pc_sequencer_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q, count_d;

  // count_q holds the number of completed wait cycles, so expire marks
  // the TIMEOUT-th wait cycle as the last one in which an ack is accepted.
  assign expire_o = (count_q == W'(TIMEOUT - 1));

  // Clear wins over counting; stop at the expire point.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - boot/fetch/advance control FSM for the PC datapath
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OFF_W   = OFF_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.master bus
);
  state_e            state_q, state_d;
  logic              pc_load_q, pc_load_d;
  logic              pc_boot_q, pc_boot_d;
  logic              pc_count_q, pc_count_d;
  logic              pc_branch_q, pc_branch_d;
  logic [OFF_W-1:0]  add_amt_q, add_amt_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              halt_lat_q, halt_lat_d;
  logic              timer_clear, timer_en, timer_expire;

  pc_sequencer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  // Next state and next output values; pulses are produced on the edge that
  // enters their state so every output port comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    pc_load_d    = 1'b0;
    pc_boot_d    = pc_boot_q;
    pc_count_d   = 1'b0;
    pc_branch_d  = 1'b0;
    add_amt_d    = '0;
    imem_req_d   = imem_req_q;
    fetch_addr_d = fetch_addr_q;
    halted_d     = 1'b0;
    error_d      = error_q;
    fcnt_d       = fcnt_q;
    halt_lat_d   = halt_lat_q;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d   = ST_LOAD;
          pc_load_d = 1'b1;
          pc_boot_d = bus.boot_sel;
          fcnt_d    = '0;
          error_d   = 1'b0;
        end else begin
          halted_d  = (state_q == ST_HALT);
        end
      end
      ST_LOAD: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d      = ST_WAIT;
        fetch_addr_d = bus.pc_addr;
        imem_req_d   = 1'b1;
        timer_clear  = 1'b1;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (bus.imem_ack) begin
          // An ack in the final wait cycle still counts as an ack.
          state_d    = ST_ADVANCE;
          imem_req_d = 1'b0;
          halt_lat_d = bus.instr_halt;
          fcnt_d     = (&fcnt_q) ? fcnt_q : fcnt_q + CNT_W'(1);
          if (bus.instr_halt) begin
            pc_branch_d = 1'b0;
          end else if (bus.instr_branch) begin
            pc_branch_d = 1'b1;
            add_amt_d   = bus.instr_off;
          end else begin
            pc_count_d  = 1'b1;
          end
        end else if (timer_expire) begin
          state_d    = ST_HALT;
          imem_req_d = 1'b0;
          error_d    = 1'b1;
          halted_d   = 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (halt_lat_q) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_load_q    <= 1'b0;
      pc_boot_q    <= 1'b0;
      pc_count_q   <= 1'b0;
      pc_branch_q  <= 1'b0;
      add_amt_q    <= '0;
      imem_req_q   <= 1'b0;
      fetch_addr_q <= '0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
      fcnt_q       <= '0;
      halt_lat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_load_q    <= pc_load_d;
      pc_boot_q    <= pc_boot_d;
      pc_count_q   <= pc_count_d;
      pc_branch_q  <= pc_branch_d;
      add_amt_q    <= add_amt_d;
      imem_req_q   <= imem_req_d;
      fetch_addr_q <= fetch_addr_d;
      halted_q     <= halted_d;
      error_q      <= error_d;
      fcnt_q       <= fcnt_d;
      halt_lat_q   <= halt_lat_d;
    end
  end

  assign bus.pc_load     = pc_load_q;
  assign bus.pc_boot     = pc_boot_q;
  assign bus.pc_count    = pc_count_q;
  assign bus.pc_branch   = pc_branch_q;
  assign bus.pc_add_amt  = add_amt_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.error       = error_q;
  assign bus.fetch_count = fcnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pc_sequencer_if #(.ADDR_W(6), .OFF_W(2), .CNT_W(8)) bus ();

  pc_sequencer #(.ADDR_W(6), .OFF_W(2), .TIMEOUT(15), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for pc_top: reacts to the control pulses.
  logic [5:0] pc_q;
  always @(posedge clock) begin
    if (reset)              pc_q <= 6'd0;
    else if (bus.pc_load)   pc_q <= boot_addr(bus.pc_boot);
    else if (bus.pc_count)  pc_q <= pc_q + 6'd4;
    else if (bus.pc_branch) pc_q <= pc_q + {2'b00, bus.pc_add_amt, 2'b00};
  end
  assign bus.pc_addr = pc_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int s, input int b, input int a, input int br, input int off, input int h);
    bus.start        = s[0];
    bus.boot_sel     = b[0];
    bus.imem_ack     = a[0];
    bus.instr_branch = br[0];
    bus.instr_off    = off[1:0];
    bus.instr_halt   = h[0];
  endtask

  typedef struct {
    int s, b, a, br, off, h;
    int st, ld, bt, cnt, brp, amt, req, hlt, err, fc;
  } vec_t;

  function automatic vec_t mk(input int s, input int b, input int a, input int br,
                              input int off, input int h, input int st, input int ld,
                              input int bt, input int cnt, input int brp, input int amt,
                              input int req, input int hlt, input int err, input int fc);
    vec_t v;
    v.s = s; v.b = b; v.a = a; v.br = br; v.off = off; v.h = h;
    v.st = st; v.ld = ld; v.bt = bt; v.cnt = cnt; v.brp = brp; v.amt = amt;
    v.req = req; v.hlt = hlt; v.err = err; v.fc = fc;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " state"},       32'(bus.state),       v.st);
    check({tag, " pc_load"},     32'(bus.pc_load),     v.ld);
    check({tag, " pc_boot"},     32'(bus.pc_boot),     v.bt);
    check({tag, " pc_count"},    32'(bus.pc_count),    v.cnt);
    check({tag, " pc_branch"},   32'(bus.pc_branch),   v.brp);
    check({tag, " pc_add_amt"},  32'(bus.pc_add_amt),  v.amt);
    check({tag, " imem_req"},    32'(bus.imem_req),    v.req);
    check({tag, " halted"},      32'(bus.halted),      v.hlt);
    check({tag, " error"},       32'(bus.error),       v.err);
    check({tag, " fetch_count"}, 32'(bus.fetch_count), v.fc);
  endtask

  vec_t tv[13];
  vec_t zero_v;

  initial begin
    int d, br, off, boot, expc;
    logic [5:0] mpc;

    //             s b a br off h | st ld bt cnt brp amt req hlt err fc
    tv[0]  = mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 1, 0, 0, 0,   3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, 0, 0, 0,   4, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tv[4]  = mk(0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tv[5]  = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tv[6]  = mk(0, 0, 1, 1, 3, 0,   4, 0, 0, 0, 1, 3, 0, 0, 0, 2);
    tv[7]  = mk(1, 0, 1, 0, 0, 1,   2, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tv[8]  = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    tv[9]  = mk(0, 0, 1, 1, 2, 1,   4, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    tv[10] = mk(0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    tv[11] = mk(0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    tv[12] = mk(1, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    zero_v = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    check_outputs("reset", zero_v);
    reset = 1'b0;
    step();
    check_outputs("idle", zero_v);

    // Table: boot, plain count, branch, ignored inputs, halt beats branch, restart.
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].s, tv[i].b, tv[i].a, tv[i].br, tv[i].off, tv[i].h);
      step();
      check_outputs($sformatf("vec%0d", i), tv[i]);
    end

    // Ack arriving in the 15th wait cycle is still accepted.
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("to1 state fetch", 32'(bus.state), 2);
    step();
    check("to1 fetch_addr", 32'(bus.fetch_addr), 32);
    for (int k = 0; k < 14; k++) begin
      step();
      check("to1 still wait", 32'(bus.state), 3);
      check("to1 req held", 32'(bus.imem_req), 1);
    end
    drive(0, 0, 1, 0, 0, 0);
    step();
    check("to1 late ack state", 32'(bus.state), 4);
    check("to1 late ack count", 32'(bus.pc_count), 1);
    check("to1 late ack error", 32'(bus.error), 0);
    check("to1 late ack fc", 32'(bus.fetch_count), 1);

    // No ack for 15 wait cycles: error halt.
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    check("to2 fetch_addr", 32'(bus.fetch_addr), 36);
    for (int k = 0; k < 14; k++) begin
      step();
      check("to2 still wait", 32'(bus.state), 3);
    end
    step();
    check("to2 state", 32'(bus.state), 5);
    check("to2 req", 32'(bus.imem_req), 0);
    check("to2 error", 32'(bus.error), 1);
    check("to2 halted", 32'(bus.halted), 1);
    check("to2 fc", 32'(bus.fetch_count), 1);
    drive(1, 0, 0, 0, 0, 0);
    step();
    check("restart state", 32'(bus.state), 1);
    check("restart load", 32'(bus.pc_load), 1);
    check("restart error", 32'(bus.error), 0);
    check("restart fc", 32'(bus.fetch_count), 0);
    check("restart halted", 32'(bus.halted), 0);

    // Randomized run of 300 instructions against a transaction-level model.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    boot = int'($urandom_range(0, 1));
    drive(1, boot, 0, 0, 0, 0);
    step();
    check("rnd load boot", 32'(bus.pc_boot), boot);
    drive(0, 0, 0, 0, 0, 0);
    step();
    mpc = boot_addr(boot[0]);
    for (int n = 1; n <= 300; n++) begin
      step();
      check("rnd wait state", 32'(bus.state), 3);
      check("rnd fetch_addr", 32'(bus.fetch_addr), 32'(mpc));
      d = int'($urandom_range(0, 14));
      for (int k = 0; k < d; k++) begin
        step();
        check("rnd wait hold", 32'(bus.state), 3);
      end
      br  = int'($urandom_range(0, 1));
      off = int'($urandom_range(0, 3));
      drive(0, 0, 1, br, off, 0);
      step();
      expc = (n > 255) ? 255 : n;
      check("rnd adv state", 32'(bus.state), 4);
      check("rnd count pulse", 32'(bus.pc_count), (br == 0) ? 1 : 0);
      check("rnd branch pulse", 32'(bus.pc_branch), br);
      check("rnd add_amt", 32'(bus.pc_add_amt), (br == 1) ? off : 0);
      check("rnd fc", 32'(bus.fetch_count), expc);
      check("rnd req low", 32'(bus.imem_req), 0);
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("rnd back to fetch", 32'(bus.state), 2);
      mpc = (br == 1) ? mpc + 6'(off * 4) : mpc + 6'd4;
    end
    check("saturated fc", 32'(bus.fetch_count), 255);

    // Reset in the middle of a wait clears every output on the next cycle.
    step();
    step();
    check("pre-reset req", 32'(bus.imem_req), 1);
    reset = 1'b1;
    step();
    check_outputs("midwait reset", zero_v);
    check("midwait fetch_addr", 32'(bus.fetch_addr), 0);
    reset = 1'b0;
    step();
    check_outputs("post reset idle", zero_v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
